// File: rtl/out_switch_pkg.sv
// Shared constants and types for the out_switch arbiter and its picker.
package out_switch_pkg;

  localparam int NUM_SRC   = 3;
  localparam int LEN_W     = 16;
  localparam int WIDE_W    = 1536;
  localparam int NARROW_W  = 256;
  localparam int WIDE_HI_W = WIDE_W - NARROW_W;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Per-source forward terms presented to the switch.
  typedef struct packed {
    logic w;
    logic n;
  } fwd_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (oh[i]) idx = idx | 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three requesters, searching from
// last_owner+1 modulo 3; one-hot result, zero when nothing requests.
module rr_pick3
  import out_switch_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last_owner,
  output logic [NUM_SRC-1:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = last_owner;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_switch_arbiter.sv
// Round-robin burst arbiter sharing out_switch_flex between three sources.
// Optional per-source beat/stall counters are built when OUT_ARB_STATS_EN is defined.
module out_switch_arbiter
  import out_switch_pkg::*;
#(
  parameter int NUM_SRC = out_switch_pkg::NUM_SRC,
  parameter int LEN_W   = out_switch_pkg::LEN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        s_valid_w,
  output logic [NUM_SRC-1:0]        s_ready_w,
  input  logic [NUM_SRC-1:0]        s_valid_n,
  output logic [NUM_SRC-1:0]        s_ready_n,
  output logic [NUM_SRC-1:0]        m_valid_w,
  output logic [NUM_SRC-1:0]        m_valid_n,
  input  logic                      m_ready_g,
  input  logic                      m_ready_h,
  input  logic [LEN_W-1:0]          cfg_burst_len,
  input  logic [NUM_SRC-1:0]        cfg_src_mask,
  output logic [NUM_SRC-1:0]        grant,
`ifdef OUT_ARB_STATS_EN
  input  logic                      stat_clr,
  output logic [NUM_SRC-1:0][31:0]  stat_beats,
  output logic [NUM_SRC-1:0][31:0]  stat_stall,
`endif
  output logic                      busy
);

  arb_state_t           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [NUM_SRC-1:0]   req_en, pick, beat_src;
  fwd_t [NUM_SRC-1:0]   fwd;
  logic                 beat, own_req, burst_done;

  assign req_en = (s_valid_w | s_valid_n) & cfg_src_mask;

  rr_pick3 u_pick (
    .req        (req_en),
    .last_owner (last_q),
    .gnt        (pick)
  );

  // grant_q is non-zero only in OWN, so it doubles as the owner select.
  // Wide waits for both slices so g and h always accept the same beat.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[i].w = grant_q[i] & s_valid_w[i] & m_ready_g & m_ready_h;
      fwd[i].n = grant_q[i] & ~s_valid_w[i] & s_valid_n[i] & m_ready_h;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign m_valid_w[i] = fwd[i].w;
    assign s_ready_w[i] = fwd[i].w;
    assign m_valid_n[i] = fwd[i].n;
    assign s_ready_n[i] = fwd[i].n;
    assign beat_src[i]  = fwd[i].w | fwd[i].n;
  end

  assign beat       = |beat_src;
  assign own_req    = |(grant_q & (s_valid_w | s_valid_n));
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // >= lets a lowered burst length cut an over-long grant on its next beat.
  assign burst_done = beat && (cfg_burst_len != '0) && (cnt_inc >= cfg_burst_len);

  assign grant = grant_q;
  assign busy  = (state_q == OWN);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_en) begin
          state_d = OWN;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (beat) cnt_d = cnt_inc;
        if (burst_done || !own_req) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = onehot_to_idx(grant_q);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OUT_ARB_STATS_EN
  // A stall is an enabled request that got no ready this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (beat_src[i]) stat_beats[i] <= stat_beats[i] + 32'd1;
        if (req_en[i] && !beat_src[i]) stat_stall[i] <= stat_stall[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_out_switch_arbiter.sv
// Randomized and directed bench for out_switch_arbiter against a behavioural
// model of the ownership/burst rules; checks outputs every cycle on negedge.
module tb_out_switch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  s_valid_w, s_valid_n, s_ready_w, s_ready_n;
  logic [2:0]  m_valid_w, m_valid_n, cfg_src_mask, grant;
  logic        m_ready_g, m_ready_h, busy;
  logic [15:0] cfg_burst_len;
`ifdef OUT_ARB_STATS_EN
  logic             stat_clr;
  logic [2:0][31:0] stat_beats, stat_stall;
  bit   [31:0]      mb [3];
  bit   [31:0]      ms [3];
`endif

  int checks = 0;
  int errors = 0;

  // model: owner index (-1 idle), previous owner, beats in current grant
  int own, last, cnt;

  int pat1 [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int pat2 [11] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 1};

  always #5 clk = ~clk;

  out_switch_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid_w     (s_valid_w),
    .s_ready_w     (s_ready_w),
    .s_valid_n     (s_valid_n),
    .s_ready_n     (s_ready_n),
    .m_valid_w     (m_valid_w),
    .m_valid_n     (m_valid_n),
    .m_ready_g     (m_ready_g),
    .m_ready_h     (m_ready_h),
    .cfg_burst_len (cfg_burst_len),
    .cfg_src_mask  (cfg_src_mask),
    .grant         (grant),
`ifdef OUT_ARB_STATS_EN
    .stat_clr      (stat_clr),
    .stat_beats    (stat_beats),
    .stat_stall    (stat_stall),
`endif
    .busy          (busy)
  );

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic [2:0] ew, en, eg, req;
    logic       eb;
    int         o;
    ew = '0; en = '0; eg = '0; eb = 1'b0;
    if (!rst_n) begin
      own = -1; last = 2; cnt = 0;
    end else if (own >= 0) begin
      o = own;
      eb = 1'b1;
      eg[o] = 1'b1;
      if (s_valid_w[o] && m_ready_g && m_ready_h) ew[o] = 1'b1;
      else if (!s_valid_w[o] && s_valid_n[o] && m_ready_h) en[o] = 1'b1;
    end
    checks++;
    if ({m_valid_w, m_valid_n, s_ready_w, s_ready_n, grant, busy} !== {ew, en, ew, en, eg, eb}) begin
      errors++;
      $display("FAIL cycle t=%0t actual mvw=%b mvn=%b rw=%b rn=%b grant=%b busy=%b required mvw=%b mvn=%b rw=%b rn=%b grant=%b busy=%b",
               $time, m_valid_w, m_valid_n, s_ready_w, s_ready_n, grant, busy, ew, en, ew, en, eg, eb);
    end
`ifdef OUT_ARB_STATS_EN
    if (!rst_n) for (int i = 0; i < 3; i++) begin mb[i] = 0; ms[i] = 0; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stat_beats[i] !== mb[i] || stat_stall[i] !== ms[i]) begin
        errors++;
        $display("FAIL stats%0d t=%0t actual beats=%0d stall=%0d required beats=%0d stall=%0d",
                 i, $time, stat_beats[i], stat_stall[i], mb[i], ms[i]);
      end
    end
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (stat_clr) begin
          mb[i] = 0; ms[i] = 0;
        end else begin
          if (ew[i] | en[i]) mb[i] = mb[i] + 1;
          if ((s_valid_w[i] | s_valid_n[i]) && cfg_src_mask[i] && !(ew[i] | en[i])) ms[i] = ms[i] + 1;
        end
      end
    end
`endif
    if (rst_n) begin
      if (own < 0) begin
        req = (s_valid_w | s_valid_n) & cfg_src_mask;
        for (int k = 1; k <= 3; k++)
          if (own < 0 && req[(last + k) % 3]) begin
            own = (last + k) % 3;
            cnt = 0;
          end
      end else begin
        o = own;
        if (ew[o] | en[o]) cnt = (cnt < 65535) ? cnt + 1 : cnt;
        if (((ew[o] | en[o]) && cfg_burst_len != 0 && cnt >= int'(cfg_burst_len)) ||
            !(s_valid_w[o] | s_valid_n[o])) begin
          last = o;
          own  = -1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s_valid_w = '0; s_valid_n = '0; m_ready_g = 1'b1; m_ready_h = 1'b1;
`ifdef OUT_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_in();
    cfg_src_mask  = 3'b111;
    cfg_burst_len = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic stimulus();
    // reset state
    idle_in();
    cfg_src_mask = 3'b111; cfg_burst_len = '0;
    rst_n = 1'b0;
    #2;
    lit("rst_grant", grant, 0);
    lit("rst_busy", busy, 0);
    lit("rst_mvw", m_valid_w, 0);
    do_reset();

    // single source, 4-beat bursts with one dead cycle between
    cfg_burst_len = 16'd4;
    step();
    s_valid_w = 3'b001;
    for (int c = 0; c < 11; c++) begin
      #2;
      lit("t1_busy", busy, pat1[c]);
      step();
    end

    // three sources, 2-beat bursts rotate 0,1,2,0
    do_reset();
    cfg_burst_len = 16'd2;
    step();
    s_valid_w = 3'b111;
    for (int c = 0; c < 11; c++) begin
      #2;
      lit("t2_grant", grant, pat2[c]);
      step();
    end

    // g-slice not ready: no wide beat and no narrow leak
    do_reset();
    step();
    s_valid_w = 3'b001; s_valid_n = 3'b001; m_ready_g = 1'b0;
    step();
    #2;
    lit("t3_grant", grant, 1);
    lit("t3_mvw_blk", m_valid_w, 0);
    lit("t3_mvn_blk", m_valid_n, 0);
    step();
    m_ready_g = 1'b1;
    #2;
    lit("t3_mvw_go", m_valid_w, 1);
    lit("t3_rn", s_ready_n, 0);

    // unlimited burst, idle release on first empty cycle
    do_reset();
    step();
    s_valid_w = 3'b010;
    for (int c = 0; c < 11; c++) begin
      if (c == 10) begin
        #2;
        lit("t4_busy10", busy, 1);
        lit("t4_mvw10", m_valid_w, 2);
      end
      step();
    end
    s_valid_w = 3'b000;
    #2;
    lit("t4_busy11", busy, 1);
    lit("t4_mvw11", m_valid_w, 0);
    step();
    #2;
    lit("t4_busy12", busy, 0);

    // async reset mid-burst, then source 0 has first priority
    do_reset();
    cfg_burst_len = 16'd8;
    step();
    s_valid_w = 3'b110;
    repeat (3) step();
    #2;
    lit("t5_beat3", m_valid_w, 2);
    rst_n = 1'b0;
    #1;
    lit("t5_rst_grant", grant, 0);
    lit("t5_rst_busy", busy, 0);
    lit("t5_rst_mvw", m_valid_w, 0);
    lit("t5_rst_rw", s_ready_w, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_valid_w = 3'b111;
    step();
    #2;
    lit("t5_first", grant, 1);

`ifdef OUT_ARB_STATS_EN
    // source 2 held off by source 0, then served for 3 beats
    do_reset();
    cfg_burst_len = 16'd3;
    step();
    s_valid_w = 3'b101;
    repeat (8) step();
    s_valid_w = 3'b000;
    step();
    #2;
    lit("st_stall2", stat_stall[2], 5);
    lit("st_beats2", stat_beats[2], 3);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #2;
    lit("st_clr_stall2", stat_stall[2], 0);
    lit("st_clr_beats2", stat_beats[2], 0);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        s_valid_w[i] = ($urandom_range(0, 3) != 0);
        s_valid_n[i] = ($urandom_range(0, 1) != 0);
      end
      if (c % 37 < 3) begin
        s_valid_w = '0; s_valid_n = '0;
      end
      m_ready_g = ($urandom_range(0, 3) != 0);
      m_ready_h = ($urandom_range(0, 3) != 0);
      if (c % 50 == 0) begin
        cfg_burst_len = 16'($urandom_range(0, 5));
        cfg_src_mask  = 3'($urandom_range(0, 7));
      end
`ifdef OUT_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      if (c == 2000) begin
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    step();
  endtask

  initial begin
    own = -1; last = 2; cnt = 0;
    fork
      forever begin
        @(negedge clk);
        model_cycle();
      end
      stimulus();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
